mole_scheduler: RTL
===================

MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 500000, clk cycles per 10 ms game tick (50 MHz clk).
REQ-002 SHALL have parameter GAME_SECONDS, default 60, length of one game in seconds.
REQ-003 SHALL have parameter NUM_BOXES, default 9, valid box numbers are 1..NUM_BOXES.
REQ-004 SHALL have port clk, input, 1, rising-edge system clock.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1, one-cycle pulse requesting a new game.
REQ-007 SHALL have port difficulty, input, 2, game speed selector, sampled on accepted start.
REQ-008 SHALL have port box_address, input, 4, box struck from the Arduino link, already synchronised to clk, 0 = no strike.
REQ-009 SHALL have port target_box, output, 4, box currently lit, 0 when none.
REQ-010 SHALL have port target_valid, output, 1, high while a target is lit.
REQ-011 SHALL have port score, output, 8, correct hits this game.
REQ-012 SHALL have port correct_hit, output, 1, one-cycle pulse on a scored hit.
REQ-013 SHALL have port wrong_hit, output, 1, one-cycle pulse on a strike of a non-lit box.
REQ-014 SHALL have port sec_remaining, output, 7, seconds left in the game.
REQ-015 SHALL have port game_over, output, 1, high in DONE.

Function
REQ-016 SHALL implement states IDLE, SPAWN, SHOW, GAP and DONE.
REQ-017 SHALL accept start only in IDLE or DONE; accepted start clears score, loads sec_remaining=GAME_SECONDS, latches difficulty and enters SPAWN next cycle.
REQ-018 SHALL ignore start in SPAWN, SHOW and GAP.
REQ-019 SHALL run a free-running 16-bit LFSR, taps 16,14,13,11, stepping every clk.
REQ-020 SHALL leave SPAWN on the first cycle where lfsr[3:0] is in 1..NUM_BOXES and differs from the previous target; target_box takes that value and state goes to SHOW.
REQ-021 SHALL hold target_valid=1 in SHOW only, for 150/100/70/50 ticks for latched difficulty 0/1/2/3.
REQ-022 SHALL go from SHOW to GAP on show timeout, with no score change.
REQ-023 SHALL hold GAP (target_valid=0, target_box=0) for 20 ticks, then enter SPAWN.
REQ-024 SHALL define a strike event as box_address nonzero and different from its value in the previous cycle.
REQ-025 SHALL, on a strike in SHOW equal to target_box, pulse correct_hit, increment score saturating at 255, and enter GAP next cycle.
REQ-026 SHALL, on a strike in SHOW not equal to target_box, pulse wrong_hit and stay in SHOW with the show timer running.
REQ-027 SHALL ignore strikes in IDLE, SPAWN, GAP and DONE (no pulses).
REQ-028 SHALL decrement sec_remaining every 100 ticks in SPAWN/SHOW/GAP; when it reaches 0, enter DONE the same cycle.
REQ-029 SHALL give timeout priority over a coincident strike: no score, no pulse.
REQ-030 SHALL, in DONE, drive target_valid=0 and target_box=0, hold score and raise game_over until the next accepted start.
REQ-031 SHALL restart the tick prescaler and phase timers at zero on every state entry, except that the second counter runs continuously through the game.

Reset
REQ-032 SHALL on reset enter IDLE with target_box=0, target_valid=0, score=0, correct_hit=0, wrong_hit=0, sec_remaining=0, game_over=0, all timers 0, LFSR=16'hACE1 and previous target=0.
REQ-033 SHALL abort any game on reset mid-operation, with all outputs at reset values the cycle reset asserts.

Structure
REQ-034 SHALL take the state enum, NUM_BOXES default, show-time table and GAP_TICKS constant from the shared package bytebasher_pkg.
REQ-035 SHALL instantiate the LFSR as sub-module lfsr16 (ports clk, reset, q[15:0]).

Verification (TICK_DIV=4, GAME_SECONDS=3)
REQ-036 SHALL check: start, difficulty=3 -> target_valid within 64 cycles, target_box in 1..9, lit exactly 200 cycles if not struck.
REQ-037 SHALL check: box_address=target_box for 3 cycles during SHOW -> one correct_hit pulse, score 0->1, target_valid low next cycle.
REQ-038 SHALL check: box_address set to a non-lit box -> one wrong_hit pulse, score unchanged, target still lit.
REQ-039 SHALL check: 1200 cycles elapse -> sec_remaining steps 3,2,1,0, game_over=1, strike on the final-timeout cycle not scored.
REQ-040 SHALL check: score preloaded to 255 via hits, one more correct hit -> score stays 255, correct_hit still pulses.
REQ-041 SHALL check: reset asserted mid-SHOW -> all outputs at reset values immediately, start mid-game ignored, consecutive targets never equal over 50 spawns.

Source files
------------

// File: rtl/bytebasher_pkg.sv
// Shared constants and types for the ByteBasher whack-a-mole game blocks.
package bytebasher_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_SHOW,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam int unsigned NUM_BOXES_DEF = 9;
  localparam int unsigned GAP_TICKS     = 20;
  localparam int unsigned SEC_TICKS     = 100;

  // Ticks a target stays lit for each difficulty level.
  function automatic logic [7:0] show_ticks(input logic [1:0] diff);
    case (diff)
      2'd0:    return 8'd150;
      2'd1:    return 8'd100;
      2'd2:    return 8'd70;
      default: return 8'd50;
    endcase
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
module lfsr16 (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= 16'hACE1;
    else       q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  end

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole game sequencer: picks targets, times show/gap phases,
// scores strikes and counts down the game clock.
module mole_scheduler
  import bytebasher_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 500000,
  parameter int unsigned GAME_SECONDS = 60,
  parameter int unsigned NUM_BOXES    = NUM_BOXES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] difficulty,
  input  logic [3:0] box_address,
  output logic [3:0] target_box,
  output logic       target_valid,
  output logic [7:0] score,
  output logic       correct_hit,
  output logic       wrong_hit,
  output logic [6:0] sec_remaining,
  output logic       game_over
);

  localparam int unsigned PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SEC_CYC = SEC_TICKS * TICK_DIV;
  localparam int unsigned SEC_W   = $clog2(SEC_CYC);

  state_e             state_q, state_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [7:0]         tick_q, tick_d;
  logic [SEC_W-1:0]   sec_cnt_q, sec_cnt_d;
  logic [6:0]         sec_q, sec_d;
  logic [7:0]         score_q, score_d;
  logic [1:0]         diff_q, diff_d;
  logic [3:0]         tbox_q, tbox_d;
  logic [3:0]         prev_q, prev_d;
  logic [3:0]         box_prev_q;
  logic               valid_q, chit_q, chit_d, whit_q, whit_d, over_q;
  logic [15:0]        lfsr_q;
  logic               unused_lfsr;

  logic in_game, tick_end, sec_end, final_to, show_to, gap_to, strike, spawn_ok;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[15:4];

  assign in_game  = (state_q == ST_SPAWN) || (state_q == ST_SHOW) || (state_q == ST_GAP);
  assign tick_end = (pre_q == PRE_W'(TICK_DIV - 1));
  assign sec_end  = in_game && (sec_cnt_q == SEC_W'(SEC_CYC - 1));
  assign final_to = sec_end && (sec_q <= 7'd1);
  assign show_to  = tick_end && (tick_q == show_ticks(diff_q) - 8'd1);
  assign gap_to   = tick_end && (tick_q == 8'(GAP_TICKS - 1));
  assign strike   = (box_address != 4'd0) && (box_address != box_prev_q);
  assign spawn_ok = (lfsr_q[3:0] != 4'd0) && (lfsr_q[3:0] <= 4'(NUM_BOXES))
                    && (lfsr_q[3:0] != prev_q);

  // Next-state and datapath; final timeout outranks every other event.
  always_comb begin
    state_d   = state_q;
    pre_d     = tick_end ? '0 : pre_q + PRE_W'(1);
    tick_d    = tick_end ? tick_q + 8'd1 : tick_q;
    sec_cnt_d = (in_game && !sec_end) ? sec_cnt_q + SEC_W'(1) : '0;
    sec_d     = sec_end ? sec_q - 7'd1 : sec_q;
    score_d   = score_q;
    diff_d    = diff_q;
    tbox_d    = tbox_q;
    prev_d    = prev_q;
    chit_d    = 1'b0;
    whit_d    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SPAWN;
          score_d = '0;
          sec_d   = 7'(GAME_SECONDS);
          diff_d  = difficulty;
        end
      end
      ST_SPAWN: begin
        if (final_to) begin
          state_d = ST_DONE;
        end else if (spawn_ok) begin
          state_d = ST_SHOW;
          tbox_d  = lfsr_q[3:0];
          prev_d  = lfsr_q[3:0];
        end
      end
      ST_SHOW: begin
        if (final_to) begin
          state_d = ST_DONE;
        end else if (show_to) begin
          state_d = ST_GAP;
        end else if (strike) begin
          if (box_address == tbox_q) begin
            chit_d  = 1'b1;
            score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            state_d = ST_GAP;
          end else begin
            whit_d = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (final_to)    state_d = ST_DONE;
        else if (gap_to) state_d = ST_SPAWN;
      end
      default: state_d = ST_IDLE;
    endcase

    // Phase timers restart on every state entry; the second counter does not.
    if (state_d != state_q) begin
      pre_d  = '0;
      tick_d = '0;
    end
    if (state_d != ST_SHOW) tbox_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pre_q      <= '0;
      tick_q     <= '0;
      sec_cnt_q  <= '0;
      sec_q      <= '0;
      score_q    <= '0;
      diff_q     <= '0;
      tbox_q     <= '0;
      prev_q     <= '0;
      box_prev_q <= '0;
      valid_q    <= 1'b0;
      chit_q     <= 1'b0;
      whit_q     <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      tick_q     <= tick_d;
      sec_cnt_q  <= sec_cnt_d;
      sec_q      <= sec_d;
      score_q    <= score_d;
      diff_q     <= diff_d;
      tbox_q     <= tbox_d;
      prev_q     <= prev_d;
      box_prev_q <= box_address;
      valid_q    <= (state_d == ST_SHOW);
      chit_q     <= chit_d;
      whit_q     <= whit_d;
      over_q     <= (state_d == ST_DONE);
    end
  end

  assign target_box    = tbox_q;
  assign target_valid  = valid_q;
  assign score         = score_q;
  assign correct_hit   = chit_q;
  assign wrong_hit     = whit_q;
  assign sec_remaining = sec_q;
  assign game_over     = over_q;

endmodule
